// File: rtl/risc_op_issue.sv
// Three-state issue sequencer (IDLE/EXEC/WB) for RV32I OP and OP-IMM with an external ALU.
// Define RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired is tied to 0.
module risc_op_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_x1,
    output logic [31:0] alu_x2,
    output logic [19:0] alu_instr,
    output logic        alu_cin,
    output logic        alu_opcode_4,
    input  logic [31:0] alu_y,
    input  logic        alu_cout,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] retired
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        supported;
    logic        unused_cout;

    // Carry-out has no consumer in this datapath.
    assign unused_cout = alu_cout;

    assign supported = (instr_q[6:0] == OPC_OP) || (instr_q[6:0] == OPC_OP_IMM);

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        result_d     = result_q;
        wb_rd_d      = wb_rd_q;
        wb_valid_d   = 1'b0;
        rf_d         = rf_q;
        instr_ready  = 1'b0;
        illegal      = 1'b0;
        alu_x1       = '0;
        alu_x2       = '0;
        alu_instr    = '0;
        alu_cin      = 1'b0;
        alu_opcode_4 = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_x1       = rf_q[instr_q[19:15]];
                alu_x2       = rf_q[instr_q[24:20]];
                alu_instr    = instr_q[31:12];
                alu_opcode_4 = instr_q[5];
                if (supported) begin
                    // wb_rd/wb_data are loaded here so they are already valid during WB
                    result_d   = alu_y;
                    wb_rd_d    = instr_q[11:7];
                    wb_valid_d = 1'b1;
                    state_d    = WB;
                end else begin
                    illegal = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                if (wb_rd_q != 5'd0) begin
                    rf_d[wb_rd_q] = result_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            result_q   <= '0;
            wb_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            result_q   <= result_d;
            wb_rd_q    <= wb_rd_d;
            wb_valid_q <= wb_valid_d;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = result_q;
    // x0 is never written, so a plain array read already returns 0 for it.
    assign dbg_data = rf_q[dbg_addr];

`ifdef RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (state_q == WB) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_risc_op_issue.sv
// Bench for risc_op_issue: behavioural ALU, schedule-based reference model, directed and random traffic.
module tb_risc_op_issue;
    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_x1, alu_x2;
    logic [19:0] alu_instr;
    logic        alu_cin, alu_opcode_4;
    logic [31:0] alu_y;
    logic        alu_cout;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;
    int tcyc = 0;
    bit rand_dbg = 0;

    risc_op_issue dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_x1(alu_x1), .alu_x2(alu_x2),
        .alu_instr(alu_instr), .alu_cin(alu_cin), .alu_opcode_4(alu_opcode_4),
        .alu_y(alu_y), .alu_cout(alu_cout), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    // RV32I integer ALU semantics for funct3 with the funct7[5] alternate bit.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3, input logic alt,
                                           input logic is_reg);
        case (f3)
            3'd0: return (is_reg && alt) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_y    = alu_fn(alu_x1,
                             alu_opcode_4 ? alu_x2 : {{20{alu_instr[19]}}, alu_instr[19:8]},
                             alu_instr[2:0], alu_instr[18], alu_opcode_4);
    assign alu_cout = ^alu_y;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: architectural registers plus the cycle at which the current instruction was taken.
    logic [31:0] m_rf [32];
    bit          m_busy = 0;
    int          m_acc = 0;
    int          cyc = 0;
    logic [31:0] m_ins = '0;
    bit          m_legal = 0;
    logic [31:0] m_res = '0;
    logic [4:0]  m_wb_rd = '0;
    logic [31:0] m_wb_data = '0;
    logic [31:0] m_ret = '0;
    bit          e_ready, exec_c, wb_c;
    logic [31:0] exp_ret;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_busy = 0;
            m_wb_rd = '0;
            m_wb_data = '0;
            m_ret = '0;
        end
        e_ready = !m_busy;
        exec_c  = m_busy && (cyc == m_acc + 1);
        wb_c    = m_busy && m_legal && (cyc == m_acc + 2);
`ifdef RETIRE_CNT_EN
        exp_ret = m_ret;
`else
        exp_ret = '0;
`endif
        chk("instr_ready", 32'(instr_ready), 32'(e_ready));
        chk("alu_x1", alu_x1, exec_c ? m_rf[m_ins[19:15]] : 32'd0);
        chk("alu_x2", alu_x2, exec_c ? m_rf[m_ins[24:20]] : 32'd0);
        chk("alu_instr", 32'(alu_instr), exec_c ? 32'(m_ins[31:12]) : 32'd0);
        chk("alu_cin", 32'(alu_cin), 32'd0);
        chk("alu_opcode_4", 32'(alu_opcode_4), 32'(exec_c && m_ins[5]));
        chk("illegal", 32'(illegal), 32'(exec_c && !m_legal));
        chk("wb_valid", 32'(wb_valid), 32'(wb_c));
        chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
        chk("wb_data", wb_data, m_wb_data);
        chk("dbg_data", dbg_data, m_rf[dbg_addr]);
        chk("retired", retired, exp_ret);
        if (!rst) begin
            if (exec_c && m_legal) begin
                m_wb_rd = m_ins[11:7];
                m_wb_data = m_res;
            end
            if (exec_c && !m_legal) m_busy = 0;
            if (wb_c) begin
                if (m_ins[11:7] != 5'd0) m_rf[m_ins[11:7]] = m_res;
                m_ret = m_ret + 32'd1;
                m_busy = 0;
            end
            if (e_ready && instr_valid) begin
                m_busy  = 1;
                m_acc   = cyc;
                m_ins   = instr;
                m_legal = (instr[6:0] == 7'h33) || (instr[6:0] == 7'h13);
                m_res   = alu_fn(m_rf[instr[19:15]],
                                 instr[5] ? m_rf[instr[24:20]] : {{20{instr[31]}}, instr[31:20]},
                                 instr[14:12], instr[30], instr[5]);
            end
        end
        cyc++;
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Offer w until accepted; returns in the cycle after acceptance, #1 past the edge.
    task automatic send(input logic [31:0] w, input bit hold, output int acc_at);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr = w;
        @(negedge clk);
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        acc_at = tcyc;
        if (!instr_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=ready_low required=accept within 10 cycles");
        end
        align();
        if (!hold) begin
            instr_valid = 1'b0;
            instr = $urandom;
        end
        if (rand_dbg) dbg_addr = 5'($urandom);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 5) w[6:0] = 7'h33;
        else if (k < 9) w[6:0] = 7'h13;
        else begin
            while (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'($urandom);
        end
        return w;
    endfunction

    int t[4];
    int ta;
`ifdef RETIRE_CNT_EN
    localparam logic [31:0] RET_AFTER_X0 = 32'd4;
`else
    localparam logic [31:0] RET_AFTER_X0 = 32'd0;
`endif

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = 5'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_x1", dbg_data, 32'd0);
        align();
        rst = 1'b0;

        // ADDI x1,x0,5 accepted on the first edge after reset release
        send(32'h00500093, 0, ta);
        @(negedge clk);
        chk("addi_exec_opc4", 32'(alu_opcode_4), 32'd0);
        @(negedge clk);
        chk("addi_wb_valid", 32'(wb_valid), 32'd1);
        chk("addi_wb_rd", 32'(wb_rd), 32'd1);
        chk("addi_wb_data", wb_data, 32'd5);
        chk("addi_dbg_old", dbg_data, 32'd0);
        @(negedge clk);
        chk("addi_dbg_new", dbg_data, 32'd5);
        chk("addi_ready_n3", 32'(instr_ready), 32'd1);
        align();

        send(32'h00700113, 0, ta);
        repeat (2) @(negedge clk);
        align();

        // ADD x3,x1,x2
        dbg_addr = 5'd3;
        send(32'h002081B3, 0, ta);
        @(negedge clk);
        chk("add_x1", alu_x1, 32'd5);
        chk("add_x2", alu_x2, 32'd7);
        chk("add_opc4", 32'(alu_opcode_4), 32'd1);
        chk("add_instr", 32'(alu_instr), 32'h00208);
        @(negedge clk);
        chk("add_wb_data", wb_data, 32'd12);
        @(negedge clk);
        chk("add_x3", dbg_data, 32'd12);
        align();

        // ADDI x0,x0,5: writeback pulses but x0 stays zero
        dbg_addr = 5'd0;
        send(32'h00500013, 0, ta);
        repeat (2) @(negedge clk);
        chk("x0_wb_valid", 32'(wb_valid), 32'd1);
        chk("x0_wb_rd", 32'(wb_rd), 32'd0);
        @(negedge clk);
        chk("x0_reads_zero", dbg_data, 32'd0);
        chk("x0_retired", retired, RET_AFTER_X0);
        align();

        // unsupported opcode
        send(32'h0000007F, 0, ta);
        @(negedge clk);
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_no_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("ill_ready_n2", 32'(instr_ready), 32'd1);
        chk("ill_wb_data_hold", wb_data, 32'd5);
        chk("ill_retired", retired, RET_AFTER_X0);
        align();

        // valid held high across four instructions
        send(32'h00100213, 1, t[0]);
        send(32'h00120213, 1, t[1]);
        send(32'h00420333, 1, t[2]);
        send(32'h401303B3, 0, t[3]);
        for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(t[i] - t[i-1]), 32'd3);
        dbg_addr = 5'd7;
        repeat (3) @(negedge clk);
        chk("b2b_x7", dbg_data, 32'hFFFF_FFFF);
        align();

        // reset during EXEC of ADDI x5,x0,9
        dbg_addr = 5'd5;
        send(32'h00900293, 0, ta);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_no_wb", 32'(wb_valid), 32'd0);
        chk("abort_idle", 32'(instr_ready), 32'd1);
        align();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_wb2", 32'(wb_valid), 32'd0);
        chk("abort_x5", dbg_data, 32'd0);
        @(negedge clk);
        chk("abort_no_wb3", 32'(wb_valid), 32'd0);
        align();

        rand_dbg = 1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                dbg_addr = 5'($urandom);
                align();
            end
            send(rand_instr(), 0, ta);
        end
        repeat (4) align();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/risc_op_issue.md
RISC_OP_ISSUE -- requirements
Module: risc_op_issue

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have these ports (name direction width meaning):
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- instr_valid  in  1  instruction offered
- instr  in  32  RV32I instruction word
- instr_ready  out  1  instruction accepted when high with instr_valid
- alu_x1  out  32  ALU operand 1 (rs1 value)
- alu_x2  out  32  ALU operand 2 (rs2 value)
- alu_instr  out  20  instruction bits [31:12] to ALU
- alu_cin  out  1  ALU carry-in
- alu_opcode_4  out  1  1 = register form, 0 = immediate form
- alu_y  in  32  ALU result
- alu_cout  in  1  ALU carry-out
- wb_valid  out  1  one-cycle pulse on register writeback
- wb_rd  out  5  destination register of current writeback
- wb_data  out  32  value written
- illegal  out  1  one-cycle pulse on unsupported opcode
- dbg_addr  in  5  debug register read address
- dbg_data  out  32  combinational register-file read at dbg_addr
- retired  out  32  retired-instruction count (macro-gated, REQ-020)

Function
REQ-003 SHALL contain a 32x32 register file; x0 SHALL read 0, and writes to x0 SHALL be discarded.
REQ-004 SHALL implement FSM states IDLE, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-005 SHALL latch instr and go IDLE->EXEC on the cycle instr_valid && instr_ready.
REQ-006 In EXEC, alu_x1 = RF[instr[19:15]], alu_x2 = RF[instr[24:20]], alu_instr = instr[31:12], alu_opcode_4 = instr[5], alu_cin = 0; outside EXEC all ALU outputs SHALL be 0.
REQ-007 Supported opcodes SHALL be instr[6:0] = 0110011 (OP) and 0010011 (OP-IMM); funct3/funct7 SHALL pass through unchecked.
REQ-008 At the end of EXEC with a supported opcode, SHALL capture alu_y into a result register and go EXEC->WB.
REQ-009 At the end of EXEC with an unsupported opcode, SHALL pulse illegal for the EXEC cycle, skip writeback and go EXEC->IDLE.
REQ-010 In WB, SHALL pulse wb_valid with wb_rd = instr[11:7] and wb_data = the captured result, write RF[rd] at the end of the cycle (unless rd = 0), then go WB->IDLE.
REQ-011 Latency: accept at cycle N, EXEC at N+1, WB at N+2, result visible on dbg_data at N+3, instr_ready high at N+3; throughput SHALL be one instruction per 3 cycles.
REQ-012 Because each instruction writes back before the next is accepted, operand reads SHALL always see the prior instruction's result; no bypass is needed.
REQ-013 If dbg_addr equals rd in the WB cycle, dbg_data SHALL show the old value that cycle and the new value the next cycle.
REQ-014 instr_valid while instr_ready = 0 SHALL be ignored; the producer holds instr stable until accepted.
REQ-015 alu_cout SHALL be ignored.
REQ-016 When wb_valid and illegal are not pulsing, they SHALL be 0 and wb_rd/wb_data SHALL hold their last values.

Reset
REQ-017 On rst, SHALL enter IDLE and clear all RF entries, latched instr, result, wb_rd, wb_data, wb_valid, illegal and retired to 0.
REQ-018 Reset asserted in EXEC or WB SHALL abort the instruction with no RF write and no pulse.
REQ-019 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-020 Macro RETIRE_CNT_EN: when defined, retired SHALL increment by 1 (wrapping at 2^32) on each WB cycle, including rd = 0 writebacks but excluding illegal instructions; when undefined, retired SHALL be tied to 0 and the counter SHALL not exist.

Verification
REQ-021 Bench SHALL model the ALU (add/sub/shift/compare per funct3) and cover:
- Reset, then instr 0x00500093 (ADDI x1,x0,5) -> wb_valid at N+2 with wb_rd = 1, wb_data = 5; dbg_addr = 1 reads 5 at N+3.
- Set x1 = 5, x2 = 7, then 0x002081B3 (ADD x3,x1,x2) -> in EXEC alu_x1 = 5, alu_x2 = 7, alu_opcode_4 = 1; x3 = 12.
- 0x00500013 (ADDI x0,x0,5) -> wb_valid pulses, x0 still reads 0; retired increments if RETIRE_CNT_EN.
- 0x0000007F -> illegal pulses at N+1, no wb_valid, instr_ready back at N+2, retired unchanged.
- instr_valid held high continuously with 4 instructions -> accepts spaced exactly 3 cycles apart.
- rst asserted in EXEC of ADDI x5,x0,9 -> no wb_valid, x5 = 0, state IDLE.
